// File: rtl/o_col_drain_pkg.sv
// Shared types for the column drain: FSM encoding and MSB-first column packing helper.
// Column 0 occupies the most significant slice of a packed row.
package o_col_drain_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Bit offset of column col's slice within a packed row of ncol words of width w.
    function automatic int unsigned col_lsb(input int unsigned col, input int unsigned ncol,
                                            input int unsigned w);
        return (ncol - 1 - col) * w;
    endfunction

endpackage

// File: rtl/o_col_drain_row.sv
// One-entry output holding register with valid/ready handshake and a load strobe.
// A load in the handshake cycle replaces the accepted row and keeps valid high.
module o_row_reg #(
    parameter int unsigned W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/o_col_drain.sv
// Drains the per-column output FIFOs of the systolic array in lockstep and
// realigns the skewed column words into whole rows for writeback.
module o_col_drain
    import o_col_drain_pkg::*;
#(
    parameter int unsigned COL    = 3,
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_CNT  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [W_CNT-1:0]      i_num_rows,
    input  logic [W_DATA*COL-1:0] i_fifo_data,
    input  logic [COL-1:0]        i_fifo_empty,
    input  logic [COL-1:0]        i_fifo_valid,
    output logic [COL-1:0]        o_fifo_re,
    output logic [W_DATA*COL-1:0] o_row,
    output logic                  o_row_valid,
    input  logic                  i_row_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    state_e           state_q, state_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             slot_free;
    logic             issue;
    logic             capture;

    // Issuing only when the slot is free (or frees this cycle) guarantees the
    // capture one cycle later never overwrites an unaccepted row.
    assign slot_free = !o_row_valid || i_row_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        issue   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    cnt_d   = i_num_rows;
                    err_d   = 1'b0;
                    state_d = (i_num_rows == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (!(|i_fifo_empty) && slot_free) begin
                    issue   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (&i_fifo_valid) begin
                    capture = 1'b1;
                    cnt_d   = cnt_q - W_CNT'(1);
                    state_d = (cnt_q == W_CNT'(1)) ? StDone : StIssue;
                end else begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    o_row_reg #(
        .W(W_DATA * COL)
    ) u_row_reg (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (capture),
        .i_data (i_fifo_data),
        .i_ready(i_row_ready),
        .o_data (o_row),
        .o_valid(o_row_valid)
    );

    assign o_fifo_re = {COL{issue}};
    assign o_busy    = (state_q != StIdle);
    assign o_done    = (state_q == StDone);
    assign o_err     = err_q;

endmodule

// File: tb/tb_o_col_drain.sv
// Directed bench for o_col_drain: column FIFO model, row scoreboard, handshake monitor.
module tb_o_col_drain;
    import o_col_drain_pkg::*;

    localparam int unsigned COL    = 3;
    localparam int unsigned W_DATA = 8;
    localparam int unsigned W_CNT  = 8;
    localparam int unsigned W_ROW  = W_DATA * COL;
    localparam int unsigned DEPTH  = 64;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              start      = 1'b0;
    logic [W_CNT-1:0]  num_rows   = '0;
    logic              row_ready  = 1'b1;
    logic [W_ROW-1:0]  fifo_data;
    logic [COL-1:0]    fifo_empty;
    logic [COL-1:0]    fifo_valid;
    logic [COL-1:0]    fifo_re;
    logic [W_ROW-1:0]  row;
    logic              row_valid;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    o_col_drain #(
        .COL   (COL),
        .W_DATA(W_DATA),
        .W_CNT (W_CNT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_num_rows  (num_rows),
        .i_fifo_data (fifo_data),
        .i_fifo_empty(fifo_empty),
        .i_fifo_valid(fifo_valid),
        .o_fifo_re   (fifo_re),
        .o_row       (row),
        .o_row_valid (row_valid),
        .i_row_ready (row_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    // Column FIFO model: written by the stimulus, popped on read enable.
    logic [W_DATA-1:0] mem [COL][DEPTH];
    int unsigned       wr_ptr [COL];
    int unsigned       rd_ptr [COL];
    logic [W_DATA-1:0] rdata [COL];
    logic [COL-1:0]    vld       = '0;
    logic [COL-1:0]    vmask     = '1;
    logic              flush_req = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < COL; c++) begin
            if (flush_req) begin
                rd_ptr[c] <= wr_ptr[c];
            end else if (fifo_re[c] && (rd_ptr[c] != wr_ptr[c])) begin
                rdata[c]  <= mem[c][rd_ptr[c] % DEPTH];
                rd_ptr[c] <= rd_ptr[c] + 1;
            end
        end
        vld <= fifo_re;
    end

    always_comb begin
        fifo_data  = '0;
        fifo_empty = '0;
        for (int c = 0; c < COL; c++) begin
            fifo_data[col_lsb(c, COL, W_DATA) +: W_DATA] = rdata[c];
            fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
        end
    end

    assign fifo_valid = vld & vmask;

    // Handshake monitor, sampled mid-cycle.
    logic [W_ROW-1:0] got [256];
    int unsigned      got_wr   = 0;
    int unsigned      re_cnt   = 0;
    int unsigned      re_split = 0;
    int unsigned      done_cnt = 0;

    always @(negedge clk) begin
        if (row_valid && row_ready) begin
            got[got_wr % 256] <= row;
            got_wr            <= got_wr + 1;
        end
        if (|fifo_re) re_cnt <= re_cnt + 1;
        if ((fifo_re != '0) && (fifo_re != '1)) re_split <= re_split + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [W_ROW-1:0] exp_q [$];
    int unsigned      got_rd = 0;
    int               n_cmp  = 0;
    int               n_bad  = 0;
    int unsigned      re0;
    int unsigned      d0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push_col(input int unsigned c, input logic [W_DATA-1:0] v);
        mem[c][wr_ptr[c] % DEPTH] = v;
        wr_ptr[c] = wr_ptr[c] + 1;
    endtask

    task automatic push_row(input logic [W_ROW-1:0] r, input bit expect_out);
        for (int c = 0; c < COL; c++) push_col(c, r[col_lsb(c, COL, W_DATA) +: W_DATA]);
        if (expect_out) exp_q.push_back(r);
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (!done && k < max) begin
            tick();
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic drain_rows();
        logic [W_ROW-1:0] e;
        while (got_rd < got_wr) begin
            if (exp_q.size() == 0) begin
                chk("row_unexpected", got_wr - got_rd, 32'd0);
                got_rd = got_wr;
            end else begin
                e = exp_q.pop_front();
                chk("row_data", {8'd0, got[got_rd % 256]}, {8'd0, e});
                got_rd++;
            end
        end
        chk("rows_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_row_valid", {31'd0, row_valid}, 32'd0);
        chk("rst_row", {8'd0, row}, 32'd0);
        chk("rst_re", {29'd0, fifo_re}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic two-row job
        re0 = re_cnt;
        d0  = done_cnt;
        push_row(24'h112233, 1'b1);
        push_row(24'h445566, 1'b1);
        start    = 1'b1;
        num_rows = 8'd2;
        tick();
        start = 1'b0;
        chk("basic_busy", {31'd0, busy}, 32'd1);
        wait_done(20);
        chk("basic_last_row", {8'd0, row}, 32'h445566);
        chk("basic_last_valid", {31'd0, row_valid}, 32'd1);
        chk("basic_err", {31'd0, err}, 32'd0);
        tick();
        drain_rows();
        chk("basic_re_pulses", re_cnt - re0, 32'd2);
        chk("basic_done_pulses", done_cnt - d0, 32'd1);
        chk("basic_idle", {31'd0, busy}, 32'd0);

        // Skewed arrival: column 2 late
        re0 = re_cnt;
        push_col(0, 8'hAA);
        push_col(1, 8'hBB);
        exp_q.push_back(24'hAABBCC);
        start    = 1'b1;
        num_rows = 8'd1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("skew_no_re", re_cnt - re0, 32'd0);
        push_col(2, 8'hCC);
        wait_done(20);
        tick();
        drain_rows();
        chk("skew_re_pulses", re_cnt - re0, 32'd1);

        // Backpressure after first row
        row_ready = 1'b0;
        push_row(24'hC0C1C2, 1'b1);
        push_row(24'hD0D1D2, 1'b1);
        start    = 1'b1;
        num_rows = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && !row_valid; k++) tick();
        chk("bp_first_valid", {31'd0, row_valid}, 32'd1);
        re0 = re_cnt;
        for (int k = 0; k < 5; k++) begin
            chk("bp_row_held", {8'd0, row}, 32'hC0C1C2);
            tick();
        end
        chk("bp_no_re", re_cnt - re0, 32'd0);
        row_ready = 1'b1;
        tick();
        chk("bp_valid_drop", {31'd0, row_valid}, 32'd0);
        tick();
        chk("bp_second_valid", {31'd0, row_valid}, 32'd1);
        chk("bp_second_row", {8'd0, row}, 32'hD0D1D2);
        wait_done(20);
        tick();
        drain_rows();
        chk("bp_re_pulses", re_cnt - re0, 32'd1);

        // Misaligned valid
        push_row(24'hE0E1E2, 1'b0);
        vmask    = 3'b101;
        start    = 1'b1;
        num_rows = 8'd1;
        tick();
        start = 1'b0;
        wait_done(20);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_row_valid", {31'd0, row_valid}, 32'd0);
        chk("mis_row_kept", {8'd0, row}, 32'hD0D1D2);
        vmask = '1;
        tick();
        chk("mis_err_sticky", {31'd0, err}, 32'd1);

        // Zero-row job, also clears the error
        re0      = re_cnt;
        start    = 1'b1;
        num_rows = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_err_clr", {31'd0, err}, 32'd0);
        tick();
        chk("zero_idle", {31'd0, busy}, 32'd0);
        chk("zero_no_re", re_cnt - re0, 32'd0);

        // Start held while busy is ignored
        re0 = re_cnt;
        push_row(24'hF0F1F2, 1'b1);
        push_row(24'h123456, 1'b1);
        start    = 1'b1;
        num_rows = 8'd2;
        tick();
        num_rows = 8'd5;
        wait_done(20);
        start = 1'b0;
        tick();
        tick();
        chk("held_idle", {31'd0, busy}, 32'd0);
        drain_rows();
        chk("held_re_pulses", re_cnt - re0, 32'd2);

        // Reset mid-job, then a fresh one-row job
        for (int k = 0; k < 4; k++) push_row(24'h010203 + 24'(k), 1'b1);
        start    = 1'b1;
        num_rows = 8'd4;
        tick();
        start = 1'b0;
        tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_row", {8'd0, row}, 32'd0);
        chk("mid_rst_valid", {31'd0, row_valid}, 32'd0);
        chk("mid_rst_re", {29'd0, fifo_re}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        flush_req = 1'b1;
        tick();
        rst       = 1'b0;
        flush_req = 1'b0;
        exp_q.delete();
        got_rd = got_wr;
        tick();
        re0 = re_cnt;
        push_row(24'h778899, 1'b1);
        start    = 1'b1;
        num_rows = 8'd1;
        tick();
        start = 1'b0;
        wait_done(20);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        tick();
        drain_rows();
        chk("post_rst_re", re_cnt - re0, 32'd1);
        chk("re_all_equal", re_split, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/o_col_drain.md
Name: o_col_drain

Overview:
- Downstream consumer of the per-column output FIFO array of the systolic array.
- Each cycle it may issue a read to all COL column FIFOs at once. It then collects the COL words returned one cycle later and assembles them into one output row.
- The row is presented on a valid/ready stream toward writeback.
- It counts rows per job and pulses done at the end of the job. This realigns skewed column results into whole rows.

Parameters:
- COL, 3, number of columns and FIFOs drained.
- W_DATA, 8, width of one column word.
- W_CNT, 8, width of the row counter and of i_num_rows.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  single-cycle job start; sampled only in IDLE.
- i_num_rows  in  W_CNT  rows to drain in this job; sampled with i_start.
- i_fifo_data  in  W_DATA*COL  FIFO read data; column 0 occupies the MSB slice [W_DATA*COL-1 -: W_DATA].
- i_fifo_empty  in  COL  per-column empty flags.
- i_fifo_valid  in  COL  per-column read data valid; high one cycle after the read enable.
- o_fifo_re  out  COL  per-column read enable; all bits always driven equal.
- o_row  out  W_DATA*COL  assembled row; same column packing as i_fifo_data.
- o_row_valid  out  1  o_row holds a valid row.
- i_row_ready  in  1  consumer accepts the row when high together with o_row_valid.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the job ends.
- o_err  out  1  sticky misalignment error; cleared by an accepted i_start.

Behaviour:
- Reset (async, i_rst=1):
  - state = IDLE.
  - o_fifo_re, o_row_valid, o_busy, o_done and o_err are 0.
  - o_row and the row counter are 0.
  - Reset mid-job abandons the job. Any FIFO data already read is lost, and the row register is cleared.
- Row slot free: slot_free = !o_row_valid | i_row_ready.
- FSM states and transitions:
  - IDLE:
    - On i_start: load cnt = i_num_rows and clear o_err.
    - If i_num_rows == 0, go to DONE. Otherwise go to ISSUE.
  - ISSUE:
    - When all bits of i_fifo_empty are 0 and slot_free, drive o_fifo_re = all ones for exactly one cycle and go to WAIT.
    - Otherwise hold with o_fifo_re = 0.
  - WAIT:
    - If i_fifo_valid is all ones:
      - Register i_fifo_data into o_row and set o_row_valid.
      - Decrement cnt.
      - If the new cnt is 0, go to DONE. Otherwise go to ISSUE.
    - If any bit of i_fifo_valid is 0:
      - Set o_err and go to DONE.
      - o_row and o_row_valid are left unchanged.
  - DONE:
    - Pulse o_done for one cycle.
    - Return to IDLE in the next cycle, even if a row is still pending on the output.
- Output handshake:
  - o_row_valid falls on the handshake cycle unless a new row is captured in that same cycle.
  - o_row is stable while o_row_valid=1 and i_row_ready=0.
  - A capture in the handshake cycle is legal, because ISSUE checked slot_free one cycle earlier. The design never overwrites a row that has not been accepted.
- Throughput: at most one row per 2 cycles. Latency from read enable to o_row_valid is 2 cycles.
- i_start outside IDLE is ignored. o_busy is high from the cycle after an accepted i_start until the cycle after o_done.
- cnt uses unsigned W_CNT arithmetic. A maximum job of 2^W_CNT - 1 rows must not wrap.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, ISSUE, WAIT, DONE, 2 bits) and the column-slice helper constant for MSB-first packing.
- Sub-module o_row_reg: a one-entry output holding register with valid/ready and a load input. All other logic stays in the top module.

Test Plan:
- Basic job: COL=3, i_num_rows=2, FIFOs preloaded with rows {0x11,0x22,0x33} and {0x44,0x55,0x66}, i_row_ready=1 throughout.
  - Expect o_row=0x112233 then 0x445566, o_fifo_re pulses exactly twice.
  - Expect o_done one cycle after the second capture and o_err=0.
- Skewed arrival: column 2 becomes non-empty 3 cycles after columns 0 and 1.
  - Expect no o_fifo_re until all columns are non-empty, then correct row 0xAABBCC.
- Backpressure: i_row_ready=0 for 5 cycles after the first row.
  - Expect o_row held constant and o_fifo_re not asserted again.
  - Expect the second row out on the cycle after i_row_ready rises plus 2 cycles.
- Misalignment: force i_fifo_valid=3'b101 in WAIT.
  - Expect o_err=1, o_done pulse, and o_row_valid unchanged.
  - Next i_start clears o_err.
- Zero rows and restart: i_num_rows=0 gives o_done on the cycle after i_start with no reads.
  - i_start held while busy must not restart the count.
- Reset mid-job: assert i_rst during WAIT of row 1 of 4.
  - All outputs go to 0 immediately.
  - A new job of 1 row completes normally.
